// File: rtl/rv32_mc_pkg.sv
// rtl/rv32_mc_pkg.sv - shared types, encodings and opcode constants for the multicycle controller
package rv32_mc_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SRL  = 5'd3,
        ALU_SRA  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_XOR  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_BEQ  = 5'd10,
        ALU_BNE  = 5'd11,
        ALU_BLT  = 5'd12,
        ALU_BGE  = 5'd13,
        ALU_BLTU = 5'd14,
        ALU_BGEU = 5'd15
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_EXEC_U    = 4'd4,
        S_WB_ALU    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_RD    = 4'd7,
        S_WB_MEM    = 4'd8,
        S_MEM_WR    = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR_ADDR = 4'd12,
        S_JALR_WB   = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        SRC1_RS1   = 2'd0,
        SRC1_PC    = 2'd1,
        SRC1_OLDPC = 2'd2,
        SRC1_ZERO  = 2'd3
    } src1_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } src2_e;

    typedef enum logic [1:0] {
        WB_ALUOUT = 2'd0,
        WB_MEMDAT = 2'd1,
        WB_LINK   = 2'd2
    } wb_sel_e;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    // Arithmetic/logic op from funct3; alt picks sub over add and sra over srl.
    function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// rtl/mc_alu_op_decode.sv - state/instruction to ALU operation and illegal-instruction flag
module mc_alu_op_decode
    import rv32_mc_pkg::*;
(
    input  state_e     state,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       illegal
);

    // Address/PC arithmetic states fall through to ADD; only execute and branch states decode funct fields.
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (state)
            S_DECODE: begin
                case (opcode)
                    OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                    OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: illegal = 1'b0;
                    default:                               illegal = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                if (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    alu_op = arith_op(funct3, funct7[5]);
                else
                    illegal = 1'b1;
            end
            S_EXEC_I: begin
                if (funct3 == 3'b001) begin
                    if (funct7 != 7'h00) illegal = 1'b1;
                    else                 alu_op  = ALU_SLL;
                end else if (funct3 == 3'b101) begin
                    if ((funct7 & 7'h5F) != 7'h00) illegal = 1'b1;
                    else                           alu_op  = arith_op(funct3, funct7[5]);
                end else begin
                    // funct7 bits are immediate bits here, so addi never becomes sub
                    alu_op = arith_op(funct3, 1'b0);
                end
            end
            S_BRANCH: begin
                case (funct3)
                    3'b000:  alu_op  = ALU_BEQ;
                    3'b001:  alu_op  = ALU_BNE;
                    3'b100:  alu_op  = ALU_BLT;
                    3'b101:  alu_op  = ALU_BGE;
                    3'b110:  alu_op  = ALU_BLTU;
                    3'b111:  alu_op  = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle RV32I main controller sequencing FETCH/DECODE/EXEC/MEM/WB
module mc_control_fsm
    import rv32_mc_pkg::*;
#(
    parameter int ALU_OP      = 16,
    parameter int RESET_STATE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        branch_feedback_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_src_sel_o,
    output logic [4:0]  ALU_op_o,
    output logic [1:0]  alu_src1_sel_o,
    output logic [1:0]  alu_src2_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_instr_o,
    output logic [3:0]  state_o
);

    localparam state_e RST_ST = state_e'(RESET_STATE[3:0]);

    state_e     state, state_next;
    logic       quiet;
    alu_op_e    dec_op;
    logic       dec_illegal;
    src1_e      src1;
    src2_e      src2;
    wb_sel_e    wb_sel;
    logic [6:0] opcode;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

    mc_alu_op_decode u_alu_dec (
        .state   (state),
        .opcode  (opcode),
        .funct3  (instr_i[14:12]),
        .funct7  (instr_i[31:25]),
        .alu_op  (dec_op),
        .illegal (dec_illegal)
    );

    // State register; quiet keeps every output idle for the cycle after reset so a request dies immediately.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= RST_ST;
            quiet <= 1'b1;
        end else begin
            state <= state_next;
            quiet <= 1'b0;
        end
    end

    // Next-state and Moore outputs; pc_we in BRANCH follows the live comparison result.
    always_comb begin
        state_next      = state;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        mem_addr_sel_o  = 1'b0;
        ir_we_o         = 1'b0;
        pc_we_o         = 1'b0;
        pc_src_sel_o    = 1'b0;
        src1            = SRC1_RS1;
        src2            = SRC2_RS2;
        rf_we_o         = 1'b0;
        wb_sel          = WB_ALUOUT;
        illegal_instr_o = 1'b0;
        ALU_op_o        = (int'(dec_op) < ALU_OP) ? dec_op : ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req_o = 1'b1;
                src1      = SRC1_PC;
                src2      = SRC2_FOUR;
                if (mem_ready_i) begin
                    ir_we_o    = 1'b1;
                    pc_we_o    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                src1 = SRC1_OLDPC;
                src2 = SRC2_IMM;
                case (opcode)
                    OPC_R:                state_next = S_EXEC_R;
                    OPC_IMM:              state_next = S_EXEC_I;
                    OPC_LOAD, OPC_STORE:  state_next = S_MEM_ADDR;
                    OPC_BRANCH:           state_next = S_BRANCH;
                    OPC_JAL:              state_next = S_JAL;
                    OPC_JALR:             state_next = S_JALR_ADDR;
                    OPC_LUI, OPC_AUIPC:   state_next = S_EXEC_U;
                    default:              state_next = S_FETCH;
                endcase
            end
            S_EXEC_R:    state_next = dec_illegal ? S_FETCH : S_WB_ALU;
            S_EXEC_I: begin
                src2       = SRC2_IMM;
                state_next = dec_illegal ? S_FETCH : S_WB_ALU;
            end
            S_EXEC_U: begin
                src1       = (opcode == OPC_LUI) ? SRC1_ZERO : SRC1_OLDPC;
                src2       = SRC2_IMM;
                state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                rf_we_o    = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                src2       = SRC2_IMM;
                state_next = (opcode == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_ready_i) state_next = S_WB_MEM;
            end
            S_WB_MEM: begin
                rf_we_o    = 1'b1;
                wb_sel     = WB_MEMDAT;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_o      = 1'b1;
                mem_we_o       = 1'b1;
                mem_addr_sel_o = 1'b1;
                if (mem_ready_i) state_next = S_FETCH;
            end
            S_BRANCH: begin
                pc_src_sel_o = 1'b1;
                pc_we_o      = branch_feedback_i & ~dec_illegal;
                state_next   = S_FETCH;
            end
            S_JAL, S_JALR_WB: begin
                rf_we_o      = 1'b1;
                wb_sel       = WB_LINK;
                pc_we_o      = 1'b1;
                pc_src_sel_o = 1'b1;
                state_next   = S_FETCH;
            end
            S_JALR_ADDR: begin
                src2       = SRC2_IMM;
                state_next = S_JALR_WB;
            end
            default: state_next = S_FETCH;
        endcase
        illegal_instr_o = dec_illegal;
        if (quiet) begin
            state_next      = S_FETCH;
            mem_req_o       = 1'b0;
            mem_we_o        = 1'b0;
            mem_addr_sel_o  = 1'b0;
            ir_we_o         = 1'b0;
            pc_we_o         = 1'b0;
            pc_src_sel_o    = 1'b0;
            src1            = SRC1_RS1;
            src2            = SRC2_RS2;
            rf_we_o         = 1'b0;
            wb_sel          = WB_ALUOUT;
            illegal_instr_o = 1'b0;
            ALU_op_o        = ALU_ADD;
        end
    end

    assign alu_src1_sel_o = src1;
    assign alu_src2_sel_o = src2;
    assign wb_sel_o       = wb_sel;
    assign state_o        = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed scoreboard bench for the multicycle controller
module tb_mc_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic [5:0] ctl;   // mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src
        logic [4:0] op;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       rfwe;
        logic [1:0] wbs;
        logic       ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        fb;
    logic        ready;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src_sel;
    logic [4:0]  alu_op;
    logic [1:0]  src1_sel, src2_sel, wb_sel;
    logic        rf_we, illegal;
    logic [3:0]  state;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .instr_i           (instr),
        .branch_feedback_i (fb),
        .mem_ready_i       (ready),
        .mem_req_o         (mem_req),
        .mem_we_o          (mem_we),
        .mem_addr_sel_o    (mem_addr_sel),
        .ir_we_o           (ir_we),
        .pc_we_o           (pc_we),
        .pc_src_sel_o      (pc_src_sel),
        .ALU_op_o          (alu_op),
        .alu_src1_sel_o    (src1_sel),
        .alu_src2_sel_o    (src2_sel),
        .rf_we_o           (rf_we),
        .wb_sel_o          (wb_sel),
        .illegal_instr_o   (illegal),
        .state_o           (state)
    );

    function automatic exp_t mk(input logic [3:0] st, input logic [5:0] ctl, input logic [4:0] op,
                                input logic [1:0] s1, input logic [1:0] s2, input logic rfwe,
                                input logic [1:0] wbs, input logic ill);
        return {st, ctl, op, s1, s2, rfwe, wbs, ill};
    endfunction

    function automatic exp_t v_quiet();                return '0; endfunction
    function automatic exp_t v_fetch(input logic r);   return mk(4'd0, {1'b1, 2'b00, r, r, 1'b0}, 5'd0, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_dec(input logic ill);   return mk(4'd1, 6'b0, 5'd0, 2'd2, 2'd1, 1'b0, 2'd0, ill); endfunction
    function automatic exp_t v_exr(input logic [4:0] op, input logic ill); return mk(4'd2, 6'b0, op, 2'd0, 2'd0, 1'b0, 2'd0, ill); endfunction
    function automatic exp_t v_exi(input logic [4:0] op, input logic ill); return mk(4'd3, 6'b0, op, 2'd0, 2'd1, 1'b0, 2'd0, ill); endfunction
    function automatic exp_t v_exu(input logic [1:0] s1); return mk(4'd4, 6'b0, 5'd0, s1, 2'd1, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_wb_alu();               return mk(4'd5, 6'b0, 5'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b0); endfunction
    function automatic exp_t v_mem_addr();             return mk(4'd6, 6'b0, 5'd0, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_mem_rd();               return mk(4'd7, 6'b101000, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_wb_mem();               return mk(4'd8, 6'b0, 5'd0, 2'd0, 2'd0, 1'b1, 2'd1, 1'b0); endfunction
    function automatic exp_t v_mem_wr();               return mk(4'd9, 6'b111000, 5'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_branch(input logic [4:0] op, input logic pw, input logic ill);
        return mk(4'd10, {4'b0000, pw, 1'b1}, op, 2'd0, 2'd0, 1'b0, 2'd0, ill);
    endfunction
    function automatic exp_t v_jal();                  return mk(4'd11, 6'b000011, 5'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0); endfunction
    function automatic exp_t v_jalr_addr();            return mk(4'd12, 6'b0, 5'd0, 2'd0, 2'd1, 1'b0, 2'd0, 1'b0); endfunction
    function automatic exp_t v_jalr_wb();              return mk(4'd13, 6'b000011, 5'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0); endfunction

    // One clock: record the expectation, compare on the falling edge, then advance past the next rising edge.
    task automatic step(input exp_t e, input string tag);
        exp_t got;
        exp_t want;
        sb.push_back(e);
        @(negedge clk);
        got = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src_sel,
               alu_op, src1_sel, src2_sel, rf_we, wb_sel, illegal};
        want = sb.pop_front();
        vectors++;
        assert (got === want)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_r(input logic [31:0] ins, input logic [4:0] op, input logic ill, input string tag);
        instr = ins;
        step(v_fetch(1'b1), {tag, "_fetch"});
        step(v_dec(1'b0), {tag, "_decode"});
        step(v_exr(op, ill), {tag, "_exec"});
        if (!ill) step(v_wb_alu(), {tag, "_wb"});
    endtask

    task automatic run_i(input logic [31:0] ins, input logic [4:0] op, input logic ill, input string tag);
        instr = ins;
        step(v_fetch(1'b1), {tag, "_fetch"});
        step(v_dec(1'b0), {tag, "_decode"});
        step(v_exi(op, ill), {tag, "_exec"});
        if (!ill) step(v_wb_alu(), {tag, "_wb"});
    endtask

    task automatic run_br(input logic [31:0] ins, input logic f, input logic [4:0] op,
                          input logic pw, input logic ill, input string tag);
        instr = ins;
        fb    = f;
        step(v_fetch(1'b1), {tag, "_fetch"});
        step(v_dec(1'b0), {tag, "_decode"});
        step(v_branch(op, pw, ill), {tag, "_branch"});
        fb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; instr = 32'h0; fb = 1'b0; ready = 1'b0;
        @(posedge clk); #1;
        step(v_quiet(), "reset_a");
        step(v_quiet(), "reset_b");
        rst = 1'b0;
        @(posedge clk); #1;

        // fetch stall then add: back in FETCH four cycles after fetch completes
        instr = 32'h002081B3;
        step(v_fetch(1'b0), "fetch_stall");
        ready = 1'b1;
        run_r(32'h002081B3, 5'd0, 1'b0, "add");
        run_r(32'h40208233, 5'd1, 1'b0, "sub");
        run_r(32'h4020D233, 5'd4, 1'b0, "sra");
        run_r(32'h0020A233, 5'd5, 1'b0, "slt");
        run_r(32'h02208233, 5'd0, 1'b1, "r_bad_funct7");

        run_i(32'h40008093, 5'd0, 1'b0, "addi_bit30");
        run_i(32'h4010D093, 5'd4, 1'b0, "srai");
        run_i(32'h40109093, 5'd0, 1'b1, "slli_bad");

        run_br(32'h00208463, 1'b1, 5'd10, 1'b1, 1'b0, "beq_taken");
        run_br(32'h00208463, 1'b0, 5'd10, 1'b0, 1'b0, "beq_not");
        run_br(32'h00209463, 1'b1, 5'd11, 1'b1, 1'b0, "bne");
        run_br(32'h0020F463, 1'b1, 5'd15, 1'b1, 1'b0, "bgeu");
        run_br(32'h0020A463, 1'b1, 5'd0,  1'b0, 1'b1, "br_f3_010");

        // load with three wait cycles on the data request
        instr = 32'h0000A183;
        step(v_fetch(1'b1), "lw_fetch");
        step(v_dec(1'b0), "lw_decode");
        step(v_mem_addr(), "lw_addr");
        ready = 1'b0;
        for (int i = 0; i < 3; i++) step(v_mem_rd(), "lw_stall");
        ready = 1'b1;
        step(v_mem_rd(), "lw_ready");
        step(v_wb_mem(), "lw_wb");

        // unsupported opcode
        instr = 32'h0000007F;
        step(v_fetch(1'b1), "ill_fetch");
        step(v_dec(1'b1), "ill_decode");

        instr = 32'h008000EF;
        step(v_fetch(1'b1), "jal_fetch");
        step(v_dec(1'b0), "jal_decode");
        step(v_jal(), "jal");

        instr = 32'h000080E7;
        step(v_fetch(1'b1), "jalr_fetch");
        step(v_dec(1'b0), "jalr_decode");
        step(v_jalr_addr(), "jalr_addr");
        step(v_jalr_wb(), "jalr_wb");

        instr = 32'h000010B7;
        step(v_fetch(1'b1), "lui_fetch");
        step(v_dec(1'b0), "lui_decode");
        step(v_exu(2'd3), "lui_exec");
        step(v_wb_alu(), "lui_wb");

        instr = 32'h00001097;
        step(v_fetch(1'b1), "auipc_fetch");
        step(v_dec(1'b0), "auipc_decode");
        step(v_exu(2'd2), "auipc_exec");
        step(v_wb_alu(), "auipc_wb");

        // store stalled, then reset lands in the middle of the request
        instr = 32'h0020A023;
        step(v_fetch(1'b1), "sw_fetch");
        step(v_dec(1'b0), "sw_decode");
        step(v_mem_addr(), "sw_addr");
        ready = 1'b0;
        step(v_mem_wr(), "sw_stall");
        rst = 1'b1;
        step(v_mem_wr(), "sw_rst_cycle");
        rst = 1'b0;
        step(v_quiet(), "sw_after_rst");

        // normal store after reset
        ready = 1'b1;
        step(v_fetch(1'b1), "sw2_fetch");
        step(v_dec(1'b0), "sw2_decode");
        step(v_mem_addr(), "sw2_addr");
        step(v_mem_wr(), "sw2_mem");
        step(v_fetch(1'b1), "sw2_done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
